// File: rtl/grf_pkg.sv
// Shared MIPS register-file definitions: widths and architectural register indices.
package grf_pkg;
    localparam int REG_W     = 32;
    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_IDX_W-1:0] REG_RA   = 5'd31;
endpackage

// File: rtl/grf_if.sv
// Register-file access bundle: two read indices, one write port and the two read results.
interface grf_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] A1;
    logic [ADDR_W-1:0] A2;
    logic [ADDR_W-1:0] A3;
    logic [DATA_W-1:0] WD;
    logic              WE;
    logic [31:0]       WPC;
    logic [DATA_W-1:0] RD1;
    logic [DATA_W-1:0] RD2;

    modport master (output A1, A2, A3, WD, WE, WPC, input RD1, RD2);
    modport slave  (input A1, A2, A3, WD, WE, WPC, output RD1, RD2);
endinterface

// File: rtl/grf_read_port.sv
// One combinational read port: $0 forced to zero, optional same-cycle write bypass.
module grf_read_port
    import grf_pkg::*;
#(
    parameter int DATA_W = REG_W,
    parameter int ADDR_W = REG_IDX_W,
    parameter bit BYPASS = 1'b1
) (
    input  logic              reset,
    input  logic [ADDR_W-1:0] idx,
    input  logic [DATA_W-1:0] regs [0:(2**ADDR_W)-1],
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_idx,
    input  logic [DATA_W-1:0] wr_dat,
    output logic [DATA_W-1:0] rd
);
    always_comb begin
        rd = '0;
        if (reset) begin
            rd = '0;
        end else if (BYPASS && wr_en && (wr_idx != '0) && (wr_idx == idx)) begin
            rd = wr_dat;
        end else if (idx != '0) begin
            rd = regs[idx];
        end
    end
endmodule

// File: rtl/grf.sv
// General register file: 2 combinational read ports, 1 synchronous write port, $0 hardwired to zero.
// Writes commit on the rising edge; reset clears all registers asynchronously.
module grf
    import grf_pkg::*;
#(
    parameter int DATA_W = REG_W,
    parameter int ADDR_W = REG_IDX_W,
    parameter bit BYPASS = 1'b1
) (
    input logic clk,
    input logic reset,
    grf_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [1:DEPTH-1];
    logic [DATA_W-1:0] view [0:DEPTH-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.WE && (bus.A3 != REG_ZERO)) begin
            regs[bus.A3] <= bus.WD;
        end
    end

    // Slot 0 is a constant so the read ports index one uniform array.
    always_comb begin
        view[0] = '0;
        for (int i = 1; i < DEPTH; i++) begin
            view[i] = regs[i];
        end
    end

    grf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rd1 (
        .reset  (reset),
        .idx    (bus.A1),
        .regs   (view),
        .wr_en  (bus.WE),
        .wr_idx (bus.A3),
        .wr_dat (bus.WD),
        .rd     (bus.RD1)
    );

    grf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rd2 (
        .reset  (reset),
        .idx    (bus.A2),
        .regs   (view),
        .wr_en  (bus.WE),
        .wr_idx (bus.A3),
        .wr_dat (bus.WD),
        .rd     (bus.RD2)
    );

`ifndef SYNTHESIS
    // Trace reports every attempted write, including ones to $0 that are dropped.
    always @(posedge clk) begin
        if (!reset && bus.WE) begin
            $display("@%h: $%d <= %h", bus.WPC, bus.A3, bus.WD);
        end
    end
`endif
endmodule
